asm_sequencer: RTL and testbench
================================

# asm_sequencer

Front-end sequencer for the ASM (accumulate-sign-multiply) compute cell. It accepts one batch-norm coefficient and a stream of pixel/weight taps from the layer buffer, and drives the ASM's `asm_reception`, `calculate_en` and `asm_send` strobes with aligned `data_bn`, `data_pix` and `data_weights`. It then deserialises the ASM's 1-bit `data_out` into a `RESULT_WIDTH`-bit result word. There is one instance per ASM cell, directly upstream of it and closing the loop on its output.

## Interface
- `IMG_WIDTH`, 16, pixel width; must match the ASM `img_width`.
- `BN_WIDTH`, 16, batch-norm coefficient width; must match the ASM `bn_width`.
- `RESULT_WIDTH`, 6, result bits shifted out of the ASM per output.
- `TAPS`, 9, pixel/weight beats per output (3x3 kernel); must be ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  single-cycle request to compute one output; ignored unless `busy`=0.
- `bn_valid` / `bn_ready`  in/out  1  handshake for the BN coefficient.
- `bn_in`  in  BN_WIDTH  BN coefficient.
- `tap_valid` / `tap_ready`  in/out  1  handshake for pixel/weight taps.
- `tap_pix`  in  IMG_WIDTH  pixel.
- `tap_weight`  in  1  binary weight (1 = +1, 0 = -1).
- `asm_reception`  out  1  load strobe to the ASM for `data_bn`.
- `calculate_en`  out  1  accumulate strobe to the ASM.
- `asm_send`  out  1  result-shift strobe to the ASM.
- `data_bn`  out  BN_WIDTH  value sent to the ASM.
- `data_pix`  out  IMG_WIDTH  value sent to the ASM.
- `data_weights`  out  1  value sent to the ASM.
- `data_out`  in  1  serial result bit from the ASM.
- `result`  out  RESULT_WIDTH  deserialised result, MSB first.
- `result_valid`  out  1  single-cycle pulse when `result` is new.
- `busy`  out  1  high from accepted `start` until the `result_valid` cycle, inclusive.

## Operation
- States: IDLE → LOAD_BN → CALC → SEND → DRAIN → IDLE.
- IDLE: `start`=1 moves to LOAD_BN.
- LOAD_BN: `bn_ready`=1. On `bn_valid`, capture `bn_in` and move to CALC.
- CALC: `tap_ready`=1 while the tap counter < TAPS. Each handshake increments the counter. When the TAPS-th beat is accepted, move to SEND.
- SEND: `asm_send`=1 for exactly RESULT_WIDTH cycles, counted by the bit counter.
- DRAIN: one cycle to capture the last `data_out` bit, then pulse `result_valid` and return to IDLE.
- Deserialiser shifts left (`result <= {result[RESULT_WIDTH-2:0], data_out}`) on each sample cycle, so the first bit sampled lands in the MSB.
- `result` holds its value until the next `result_valid`.
- `data_bn`, `data_pix` and `data_weights` hold their last value when their strobes are low; they are never zeroed after reset.
- Counter widths: tap counter `$clog2(TAPS+1)`, bit counter `$clog2(RESULT_WIDTH+1)`. No wrap is permitted; each counter clears on entry to its state.
- Ready signals are combinational from state and counter only, never from `*_valid`.
- `start` while `busy`=1 is dropped with no effect.
- `tap_valid` in any state other than CALC is not accepted.
- Reset mid-operation: return to IDLE, with no `result_valid` and no further strobes.

## Timing
- Reset values: all strobes, `bn_ready`, `tap_ready`, `busy` and `result_valid` are 0; `result`, `data_bn`, `data_pix` and `data_weights` are 0; state is IDLE.
- All ASM-side outputs are registered.
- BN accepted at cycle t → `asm_reception`=1 with `data_bn`=`bn_in` at t+1; `tap_ready` may rise at t+1.
- Tap accepted at cycle t → `calculate_en`=1 with `data_pix`/`data_weights` at t+1. Back-to-back taps give back-to-back `calculate_en`.
- Last tap accepted at t → `asm_send` high during t+2 … t+1+RESULT_WIDTH. `calculate_en` and `asm_send` never overlap.
- ASM contract: `data_out` bit k is valid the cycle after the k-th `asm_send` cycle. Sampling therefore covers t+3 … t+2+RESULT_WIDTH.
- `result_valid` fires at t+3+RESULT_WIDTH; `busy` falls the following cycle.
- Minimum start-to-start interval: TAPS + RESULT_WIDTH + 5 cycles.

## Structure
- Shared package `asm_pkg`:
  - state enum `asm_seq_state_t`;
  - default width constants `IMG_WIDTH_D`, `BN_WIDTH_D` and `RESULT_WIDTH_D`, shared with the ASM and its bench.
- One sub-module, `asm_result_deser`: a RESULT_WIDTH shift register with sample-enable input and `result_valid` generation, reusable at the output of other serial cells.

## Test plan
- Reset, then idle for 10 cycles → every output stays 0; `bn_ready` = `tap_ready` = 0.
- BN 0x1234, 9 taps back-to-back with pixels 1…9 and weights alternating 1/0 → one `asm_reception` carrying 0x1234, then 9 consecutive `calculate_en` cycles with matching pix/weight, then 6 `asm_send` cycles.
- During SEND, drive `data_out` with model bits 1,0,1,1,0,1 → `result`=6'b101101, `result_valid` exactly 3+6 cycles after the last tap accept, `busy` low one cycle later.
- Taps with `tap_valid` gaps of 0–3 random cycles → `calculate_en` count is exactly 9, with no beat lost or duplicated; `tap_ready` drops after the 9th beat.
- `start` pulsed while `busy`, and `tap_valid` held during LOAD_BN → no second operation, and no tap accepted before the BN handshake.
- `rst` asserted mid-CALC (after 4 taps), then a fresh `start` → outputs return to 0 asynchronously, no `result_valid`; the new run completes with a full 9-tap count.

Source files
------------

// File: rtl/asm_pkg.sv
// -----------------------------------------------------------------------------
// asm_pkg
// Shared definitions for the ASM (accumulate-sign-multiply) cell front end:
// the sequencer state encoding and the default data widths used by the ASM,
// its sequencer and their benches.
// -----------------------------------------------------------------------------
package asm_pkg;

    localparam int IMG_WIDTH_D    = 16;
    localparam int BN_WIDTH_D     = 16;
    localparam int RESULT_WIDTH_D = 6;
    localparam int TAPS_D         = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_BN = 3'd1,
        ST_CALC    = 3'd2,
        ST_SEND    = 3'd3,
        ST_DRAIN   = 3'd4
    } asm_seq_state_t;

endpackage

// File: rtl/asm_result_deser.sv
// -----------------------------------------------------------------------------
// asm_result_deser
// MSB-first deserialiser for a serial result stream. Every cycle with
// i_sample_en high shifts i_bit into the LSB. When the sample is also flagged
// as the last one of the word, the completed word is copied to result and
// result_valid pulses for one cycle. result holds until the next word.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   i_sample_en   in   shift i_bit in this cycle
//   i_sample_last in   this sample completes the word (qualified by i_sample_en)
//   i_bit         in   serial data bit
//   result        out  RESULT_WIDTH-bit word, first sampled bit in the MSB
//   result_valid  out  one-cycle pulse when result is updated
// -----------------------------------------------------------------------------
module asm_result_deser #(
    parameter int RESULT_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_sample_en,
    input  logic                    i_sample_last,
    input  logic                    i_bit,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    result_valid
);

    logic [RESULT_WIDTH-1:0] r_shift;
    logic [RESULT_WIDTH-1:0] r_result;
    logic                    r_result_valid;
    logic [RESULT_WIDTH-1:0] w_shift_nxt;

    // A one-bit word has nothing to shift; the new bit is the whole word.
    if (RESULT_WIDTH == 1) begin : g_one
        assign w_shift_nxt = i_bit;
    end else begin : g_multi
        assign w_shift_nxt = {r_shift[RESULT_WIDTH-2:0], i_bit};
    end

    // Shift register, result holding register and valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (i_sample_en) begin
                r_shift <= w_shift_nxt;
            end else begin
                r_shift <= r_shift;
            end
            // Publish the full word (including the bit arriving now) at once so
            // result never exposes a partially shifted value.
            if (i_sample_en && i_sample_last) begin
                r_result       <= w_shift_nxt;
                r_result_valid <= 1'b1;
            end else begin
                r_result       <= r_result;
                r_result_valid <= 1'b0;
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: rtl/asm_sequencer.sv
// -----------------------------------------------------------------------------
// asm_sequencer
// Front-end sequencer for one ASM compute cell. For each start it takes one
// batch-norm coefficient and TAPS pixel/weight beats, drives them into the
// ASM with the asm_reception / calculate_en strobes, then issues RESULT_WIDTH
// asm_send strobes and deserialises the ASM's serial data_out into result.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   start                          request one output (ignored while busy)
//   bn_valid/bn_ready/bn_in        BN coefficient handshake
//   tap_valid/tap_ready            pixel/weight tap handshake
//   tap_pix, tap_weight            tap payload (weight 1 = +1, 0 = -1)
//   asm_reception, calculate_en,
//   asm_send                       registered strobes to the ASM
//   data_bn, data_pix, data_weights registered data to the ASM (held)
//   data_out                       serial result bit from the ASM
//   result, result_valid           deserialised result and its pulse
//   busy                           accepted start .. result_valid inclusive
// -----------------------------------------------------------------------------
module asm_sequencer
    import asm_pkg::*;
#(
    parameter int IMG_WIDTH    = IMG_WIDTH_D,
    parameter int BN_WIDTH     = BN_WIDTH_D,
    parameter int RESULT_WIDTH = RESULT_WIDTH_D,
    parameter int TAPS         = TAPS_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bn_valid,
    output logic                    bn_ready,
    input  logic [BN_WIDTH-1:0]     bn_in,
    input  logic                    tap_valid,
    output logic                    tap_ready,
    input  logic [IMG_WIDTH-1:0]    tap_pix,
    input  logic                    tap_weight,
    output logic                    asm_reception,
    output logic                    calculate_en,
    output logic                    asm_send,
    output logic [BN_WIDTH-1:0]     data_bn,
    output logic [IMG_WIDTH-1:0]    data_pix,
    output logic                    data_weights,
    input  logic                    data_out,
    output logic [RESULT_WIDTH-1:0] result,
    output logic                    result_valid,
    output logic                    busy
);

    localparam int TAP_CW = $clog2(TAPS + 1);
    localparam int BIT_CW = $clog2(RESULT_WIDTH + 1);

    localparam logic [TAP_CW-1:0] TAPS_C    = TAP_CW'(TAPS);
    localparam logic [TAP_CW-1:0] TAP_LAST  = TAP_CW'(TAPS - 1);
    localparam logic [TAP_CW-1:0] TAP_ONE   = TAP_CW'(1);
    localparam logic [BIT_CW-1:0] RES_C     = BIT_CW'(RESULT_WIDTH);
    localparam logic [BIT_CW-1:0] BIT_ONE   = BIT_CW'(1);

    asm_seq_state_t        r_state;
    asm_seq_state_t        w_state_nxt;
    logic [TAP_CW-1:0]     r_tap_cnt;
    logic [TAP_CW-1:0]     w_tap_cnt_nxt;
    logic [BIT_CW-1:0]     r_bit_cnt;
    logic [BIT_CW-1:0]     w_bit_cnt_nxt;

    logic                  w_bn_ready;
    logic                  w_tap_ready;
    logic                  w_start_acc;
    logic                  w_bn_acc;
    logic                  w_tap_acc;
    logic                  w_send_nxt;
    logic                  w_sample_last;
    logic                  w_result_valid;

    logic                  r_asm_reception;
    logic                  r_calc_en;
    logic                  r_asm_send;
    logic                  r_sample;
    logic [BN_WIDTH-1:0]   r_data_bn;
    logic [IMG_WIDTH-1:0]  r_data_pix;
    logic                  r_data_weights;
    logic                  r_busy;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter updates, handshake readiness and accept decodes.
    always_comb begin
        w_state_nxt   = r_state;
        w_tap_cnt_nxt = r_tap_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_bn_ready    = 1'b0;
        w_tap_ready   = 1'b0;
        w_start_acc   = 1'b0;
        w_bn_acc      = 1'b0;
        w_tap_acc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // busy also covers the result_valid cycle, spent here in IDLE.
                if (start && !r_busy) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_LOAD_BN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD_BN: begin
                w_bn_ready = 1'b1;
                if (bn_valid) begin
                    w_bn_acc      = 1'b1;
                    w_tap_cnt_nxt = '0;
                    w_state_nxt   = ST_CALC;
                end else begin
                    w_state_nxt = ST_LOAD_BN;
                end
            end
            ST_CALC: begin
                if (r_tap_cnt < TAPS_C) begin
                    w_tap_ready = 1'b1;
                    if (tap_valid) begin
                        w_tap_acc     = 1'b1;
                        w_tap_cnt_nxt = r_tap_cnt + TAP_ONE;
                        if (r_tap_cnt == TAP_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = ST_SEND;
                        end else begin
                            w_state_nxt = ST_CALC;
                        end
                    end else begin
                        w_state_nxt = ST_CALC;
                    end
                end else begin
                    // Counter already saturated: never stall here.
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_SEND;
                end
            end
            ST_SEND: begin
                // One extra SEND cycle (count == RES_C) lets the registered
                // asm_send strobe cover exactly RESULT_WIDTH cycles.
                if (r_bit_cnt == RES_C) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
                    w_state_nxt   = ST_SEND;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_send_nxt    = (r_state == ST_SEND) && (r_bit_cnt < RES_C);
    // DRAIN coincides with the final sample cycle of data_out.
    assign w_sample_last = (r_state == ST_DRAIN);

    // Counters, registered ASM strobes/data, sample enable and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tap_cnt       <= '0;
            r_bit_cnt       <= '0;
            r_asm_reception <= 1'b0;
            r_calc_en       <= 1'b0;
            r_asm_send      <= 1'b0;
            r_sample        <= 1'b0;
            r_data_bn       <= '0;
            r_data_pix      <= '0;
            r_data_weights  <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_tap_cnt       <= w_tap_cnt_nxt;
            r_bit_cnt       <= w_bit_cnt_nxt;
            r_asm_reception <= w_bn_acc;
            r_calc_en       <= w_tap_acc;
            r_asm_send      <= w_send_nxt;
            // The ASM presents bit k the cycle after the k-th asm_send.
            r_sample        <= r_asm_send;
            if (w_bn_acc) begin
                r_data_bn <= bn_in;
            end else begin
                r_data_bn <= r_data_bn;
            end
            if (w_tap_acc) begin
                r_data_pix     <= tap_pix;
                r_data_weights <= tap_weight;
            end else begin
                r_data_pix     <= r_data_pix;
                r_data_weights <= r_data_weights;
            end
            if (w_start_acc) begin
                r_busy <= 1'b1;
            end else if (w_result_valid) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    asm_result_deser #(
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_deser (
        .clk           (clk),
        .rst           (rst),
        .i_sample_en   (r_sample),
        .i_sample_last (w_sample_last),
        .i_bit         (data_out),
        .result        (result),
        .result_valid  (w_result_valid)
    );

    assign bn_ready      = w_bn_ready;
    assign tap_ready     = w_tap_ready;
    assign asm_reception = r_asm_reception;
    assign calculate_en  = r_calc_en;
    assign asm_send      = r_asm_send;
    assign data_bn       = r_data_bn;
    assign data_pix      = r_data_pix;
    assign data_weights  = r_data_weights;
    assign result_valid  = w_result_valid;
    assign busy          = r_busy;

endmodule

// File: tb/tb_asm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_asm_sequencer
// Directed self-checking bench for asm_sequencer (default parameters:
// 16-bit pixel/BN, 6-bit result, 9 taps). Inputs change 1 time unit after the
// rising edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_asm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bn_valid;
    logic        bn_ready;
    logic [15:0] bn_in;
    logic        tap_valid;
    logic        tap_ready;
    logic [15:0] tap_pix;
    logic        tap_weight;
    logic        asm_reception;
    logic        calculate_en;
    logic        asm_send;
    logic [15:0] data_bn;
    logic [15:0] data_pix;
    logic        data_weights;
    logic        data_out;
    logic [5:0]  result;
    logic        result_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Monitor state
    int          m_rec_cnt, m_rec_cyc, m_bn_acc_cyc, m_tap_acc_cnt, m_last_tap_cyc;
    int          m_calc_cnt, m_send_cnt, m_send_first, m_overlap;
    int          m_rv_cnt, m_rv_cyc, m_busy_fall, m_late_ready;
    logic [15:0] m_rec_bn;
    logic [5:0]  m_result;
    logic [15:0] obs_pix [16];
    logic        obs_w   [16];
    logic        m_prev_busy = 1'b0;
    logic [5:0]  exp_bits = 6'd0;
    logic        pend_bit = 1'b0;
    logic        pend_v   = 1'b0;

    asm_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .bn_valid      (bn_valid),
        .bn_ready      (bn_ready),
        .bn_in         (bn_in),
        .tap_valid     (tap_valid),
        .tap_ready     (tap_ready),
        .tap_pix       (tap_pix),
        .tap_weight    (tap_weight),
        .asm_reception (asm_reception),
        .calculate_en  (calculate_en),
        .asm_send      (asm_send),
        .data_bn       (data_bn),
        .data_pix      (data_pix),
        .data_weights  (data_weights),
        .data_out      (data_out),
        .result        (result),
        .result_valid  (result_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // ASM model: bit k of exp_bits (MSB first) appears the cycle after the k-th asm_send.
    always @(posedge clk) begin
        #1;
        data_out = pend_v ? pend_bit : 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (m_tap_acc_cnt >= 9 && tap_ready) m_late_ready++;
            if (bn_valid && bn_ready) m_bn_acc_cyc = cyc;
            if (asm_reception) begin
                m_rec_cnt++;
                m_rec_cyc = cyc;
                m_rec_bn  = data_bn;
            end
            if (tap_valid && tap_ready) begin
                m_tap_acc_cnt++;
                m_last_tap_cyc = cyc;
            end
            if (calculate_en) begin
                if (m_calc_cnt < 16) begin
                    obs_pix[m_calc_cnt] = data_pix;
                    obs_w[m_calc_cnt]   = data_weights;
                end
                m_calc_cnt++;
            end
            if (asm_send) begin
                if (m_send_cnt == 0) m_send_first = cyc;
                pend_bit = (m_send_cnt < 6) ? exp_bits[5 - m_send_cnt] : 1'b0;
                pend_v   = 1'b1;
                m_send_cnt++;
            end else begin
                pend_v = 1'b0;
            end
            if (asm_send && calculate_en) m_overlap++;
            if (result_valid) begin
                m_rv_cnt++;
                m_rv_cyc = cyc;
                m_result = result;
            end
            if (m_prev_busy && !busy) m_busy_fall = cyc;
            m_prev_busy = busy;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        m_rec_cnt = 0; m_rec_cyc = -1; m_bn_acc_cyc = -100; m_tap_acc_cnt = 0;
        m_last_tap_cyc = -100; m_calc_cnt = 0; m_send_cnt = 0; m_send_first = -1;
        m_overlap = 0; m_rv_cnt = 0; m_rv_cyc = -1; m_busy_fall = -1; m_late_ready = 0;
        m_rec_bn = 16'd0; m_result = 6'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_bn(input logic [15:0] bn);
        bit ok;
        ok       = 1'b0;
        bn_valid = 1'b1;
        bn_in    = bn;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bn_ready;
            tick();
        end
        bn_valid = 1'b0;
        if (!ok) chk("bn_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_tap(input logic [15:0] pix, input logic w, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) tick();
        tap_valid  = 1'b1;
        tap_pix    = pix;
        tap_weight = w;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = tap_ready;
            tick();
        end
        tap_valid = 1'b0;
        if (!ok) chk("tap_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [15:0] bn, input int max_gap, input logic [5:0] bits,
                          input logic [15:0] pix_base, input bit hold_tap,
                          input bit start_busy, input logic [5:0] prev_result);
        bit   got;
        logic acc;
        int   t;
        clear_mon();
        exp_bits = bits;
        do_start();
        if (hold_tap) begin
            tap_valid  = 1'b1;
            tap_pix    = 16'hDEAD;
            tap_weight = 1'b1;
            repeat (3) tick();
        end
        do_bn(bn);
        tap_valid = 1'b0;
        chk("no_early_tap", m_tap_acc_cnt, 0);
        chk("hold_result", result, prev_result);
        for (int i = 0; i < 9; i++) begin
            do_tap(pix_base + 16'(i), (i % 2 == 0), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        end
        if (start_busy) do_start();
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = result_valid;
            tick();
        end
        if (!got) chk("rv_timeout", 64'd0, 64'd1);
        repeat (3) tick();
        t = m_last_tap_cyc;
        chk("rec_cnt", m_rec_cnt, 1);
        chk("rec_bn", m_rec_bn, bn);
        chk("rec_cyc", m_rec_cyc, m_bn_acc_cyc + 1);
        chk("tap_acc_cnt", m_tap_acc_cnt, 9);
        chk("calc_cnt", m_calc_cnt, 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("pix%0d", i), obs_pix[i], pix_base + 16'(i));
            chk($sformatf("w%0d", i), obs_w[i], (i % 2 == 0));
        end
        chk("late_ready", m_late_ready, 0);
        chk("send_cnt", m_send_cnt, 6);
        chk("send_first", m_send_first, t + 2);
        chk("overlap", m_overlap, 0);
        chk("rv_cnt", m_rv_cnt, 1);
        chk("rv_cyc", m_rv_cyc, t + 9);
        chk("result", m_result, bits);
        chk("busy_fall", m_busy_fall, t + 10);
        if (start_busy) begin
            acc = 1'b0;
            repeat (5) begin
                @(negedge clk);
                acc = acc | bn_ready | busy;
                tick();
            end
            chk("no_second_op", acc, 0);
        end
    endtask

    initial begin
        logic [45:0] acc;
        rst = 1'b0; start = 1'b0; bn_valid = 1'b0; bn_in = 16'd0;
        tap_valid = 1'b0; tap_pix = 16'd0; tap_weight = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("reset_outs", {asm_reception, calculate_en, asm_send, data_bn, data_pix, data_weights,
                           result, result_valid, busy, bn_ready, tap_ready}, 64'd0);
        rst = 1'b1;
        acc = '0;
        repeat (10) begin
            @(negedge clk);
            acc = acc | {asm_reception, calculate_en, asm_send, data_bn, data_pix, data_weights,
                         result, result_valid, busy, bn_ready, tap_ready};
            tick();
        end
        chk("idle_outs", acc, 64'd0);

        run_op(16'h1234, 0, 6'b101101, 16'd1,     1'b0, 1'b0, 6'b000000);
        run_op(16'hBEEF, 3, 6'b011001, 16'h0100, 1'b0, 1'b0, 6'b101101);
        run_op(16'h0F0F, 1, 6'b110010, 16'h0200, 1'b1, 1'b1, 6'b011001);

        // Reset in the middle of CALC after four taps.
        clear_mon();
        do_start();
        do_bn(16'h5555);
        for (int i = 0; i < 4; i++) do_tap(16'h0400 + 16'(i), 1'b1, 0);
        chk("pre_rst_calc", calculate_en, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async", {busy, calculate_en, tap_ready, asm_reception, asm_send, result_valid,
                          data_pix, data_bn, result, data_weights}, 64'd0);
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) tick();
        chk("post_rst", {m_rv_cnt, busy, bn_ready, tap_ready}, 64'd0);

        run_op(16'h00A5, 0, 6'b111000, 16'h0300, 1'b0, 1'b0, 6'b000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
